// File: rtl/gpioemu_host_master_if.sv
`default_nettype none
// ============================================================================
// Module  : gpioemu_host_master_if
// Brief   : saddress/srd/swr bus between the host master and the peripheral.
// Revision: 1.0
// ============================================================================
interface gpioemu_host_master_if;
    logic [15:0] m_addr;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        output m_addr,
        output m_rd,
        output m_wr,
        output m_wdata,
        input  m_rdata
    );

    modport slave (
        input  m_addr,
        input  m_rd,
        input  m_wr,
        input  m_wdata,
        output m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/gpioemu_host_master.sv
`default_nettype none
// ============================================================================
// Module  : gpioemu_host_master
// Brief   : Runs one multiply/popcount job on the GPIO peripheral over the bus.
// Revision: 1.0
// ============================================================================
module gpioemu_host_master #(
    parameter int          SETUP_CYCLES  = 1,
    parameter int          STROBE_CYCLES = 2,
    parameter int          POLL_MAX      = 255,
    parameter logic [15:0] ADDR_A1       = 16'h0380,
    parameter logic [15:0] ADDR_A2       = 16'h0388,
    parameter logic [15:0] ADDR_W        = 16'h0390,
    parameter logic [15:0] ADDR_L        = 16'h0398,
    parameter logic [15:0] ADDR_CTRL     = 16'h03A0
) (
    input  wire                   clk,
    input  wire                   n_reset,
    input  wire                   start_i,
    input  wire  [23:0]           a1_i,
    input  wire  [23:0]           a2_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [31:0]           w_o,
    output logic [23:0]           l_o,
    output logic [1:0]            stat_o,
    output logic [15:0]           job_count_o,
    gpioemu_host_master_if.master bus
);

    localparam int CW = 8;
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_A1   = 4'd1,
        S_WR_A2   = 4'd2,
        S_WR_CTRL = 4'd3,
        S_RD_STAT = 4'd4,
        S_RD_W    = 4'd5,
        S_RD_L    = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   poll_q;
    logic [23:0]     a1_q, a2_q;
    logic [31:0]     w_q;
    logic [23:0]     l_q;
    logic [1:0]      stat_q;
    logic            timeout_q;
    logic [15:0]     job_count_q;

    logic            w_busy;
    logic            w_accept;
    logic            w_last_strobe;
    logic            w_access_end;
    logic            w_is_rd;
    logic [15:0]     w_addr;
    logic [31:0]     w_wdata;

    assign w_busy = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        w_accept      = 1'b0;
        w_last_strobe = 1'b0;
        w_access_end  = 1'b0;

        if (w_busy) begin
            case (phase_q)
                PH_SETUP: begin
                    if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                        phase_d = PH_STROBE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_STROBE: begin
                    if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
                        phase_d       = PH_HOLD;
                        cnt_d         = '0;
                        w_last_strobe = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_d      = PH_SETUP;
                    cnt_d        = '0;
                    w_access_end = 1'b1;
                end
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d  = S_WR_A1;
                    w_accept = 1'b1;
                end
            end
            S_WR_A1:   if (w_access_end) state_d = S_WR_A2;
            S_WR_A2:   if (w_access_end) state_d = S_WR_CTRL;
            S_WR_CTRL: if (w_access_end) state_d = S_RD_STAT;
            S_RD_STAT: begin
                // stat_q already holds this poll's status: it was captured on the last strobe cycle
                if (w_access_end) begin
                    if (stat_q == 2'b11) begin
                        state_d = S_RD_W;
                    end else if (poll_q == PW'(POLL_MAX)) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RD_W:    if (w_access_end) state_d = S_RD_L;
            S_RD_L:    if (w_access_end) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr  = 16'h0000;
        w_wdata = 32'h0000_0000;
        w_is_rd = 1'b0;
        case (state_q)
            S_WR_A1:   begin w_addr = ADDR_A1;   w_wdata = {8'h00, a1_q}; end
            S_WR_A2:   begin w_addr = ADDR_A2;   w_wdata = {8'h00, a2_q}; end
            S_WR_CTRL: begin w_addr = ADDR_CTRL; w_wdata = 32'h0000_0001; end
            S_RD_STAT: begin w_addr = ADDR_CTRL; w_is_rd = 1'b1; end
            S_RD_W:    begin w_addr = ADDR_W;    w_is_rd = 1'b1; end
            S_RD_L:    begin w_addr = ADDR_L;    w_is_rd = 1'b1; end
            default:   ;
        endcase
    end

    // Strobes decode straight from registered state so an async reset drops them at once
    assign bus.m_addr  = w_addr;
    assign bus.m_wdata = w_wdata;
    assign bus.m_rd    = w_is_rd && (phase_q == PH_STROBE);
    assign bus.m_wr    = w_busy && !w_is_rd && (phase_q == PH_STROBE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            poll_q      <= '0;
            a1_q        <= 24'h0;
            a2_q        <= 24'h0;
            w_q         <= 32'h0;
            l_q         <= 24'h0;
            stat_q      <= 2'b00;
            timeout_q   <= 1'b0;
            job_count_q <= 16'h0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                a1_q      <= a1_i;
                a2_q      <= a2_i;
                timeout_q <= 1'b0;
                poll_q    <= '0;
            end
            if (w_last_strobe) begin
                case (state_q)
                    S_RD_STAT: begin
                        stat_q <= bus.m_rdata[1:0];
                        poll_q <= poll_q + 1'b1;
                    end
                    S_RD_W:  w_q <= bus.m_rdata;
                    S_RD_L:  l_q <= bus.m_rdata[23:0];
                    default: ;
                endcase
            end
            if (state_q == S_RD_STAT && state_d == S_ERR) begin
                timeout_q <= 1'b1;
            end
            if (state_q == S_RD_L && state_d == S_DONE) begin
                job_count_q <= job_count_q + 1'b1;
            end
        end
    end

    assign busy_o      = w_busy;
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign timeout_o   = timeout_q;
    assign w_o         = w_q;
    assign l_o         = l_q;
    assign stat_o      = stat_q;
    assign job_count_o = job_count_q;

endmodule
`default_nettype wire
